fir_feeder: RTL and testbench

Host-side initiator for the FIR filter controller's `dr`/`lc` handshake.
- Accepts sample and coefficient words from the host through a 4-deep queue.
- Presents each word on `sample_data` or `fir_coefficient` and generates the `dr` or `lc` strobe with the timing the controller requires.
- Tracks the controller's `modwait` to know when each operation finishes.
- Reports per-sample completion with the controller's `err`, plus sticky protocol and timeout errors.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/feeder_fifo.sv | 67 ++++++
 rtl/fir_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_fir_feeder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared types and constants for the FIR controller, datapath
//               and the host-side feeder.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  // Datapath word width shared by controller, datapath and feeder
  localparam int DATA_W  = 16;
  // Feeder queue entry: {kind, data}
  localparam int ENTRY_W = DATA_W + 1;

  // Word kind tag carried in the MSB of each queue entry
  localparam logic KIND_SAMPLE = 1'b0;
  localparam logic KIND_COEFF  = 1'b1;

  // Feeder handshake FSM
  typedef enum logic [2:0] {
    F_IDLE  = 3'd0,
    F_DR1   = 3'd1,
    F_DR2   = 3'd2,
    F_LC    = 3'd3,
    F_WRISE = 3'd4,
    F_WFALL = 3'd5
  } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/feeder_fifo.sv
`default_nettype none
// ============================================================================
// Module      : feeder_fifo
// Description : Synchronous FIFO holding host words for the feeder. DEPTH
//               must be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
// ============================================================================
module feeder_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_reset,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_full  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  // A push into a full queue is accepted only when a pop frees a slot
  assign w_push  = push_i & (~w_full | pop_i);
  assign w_pop   = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_feeder.sv
`default_nettype none
// ============================================================================
// Module      : fir_feeder
// Description : Host-side initiator for the FIR controller dr/lc handshake.
//               Queues host words, strobes them into the controller, tracks
//               modwait to completion and reports done / sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_feeder
  import fir_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int DEPTH   = 4
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              push_valid,
  input  logic              push_kind,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              clear_err,
  input  logic              modwait,
  input  logic              err,
  output logic              dr,
  output logic              lc,
  output logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] fir_coefficient,
  output logic              done,
  output logic              done_err,
  output logic [1:0]        coeff_idx,
  output logic              busy,
  output logic              proto_err,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int TMO_W = 6;

  feeder_state_e state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              kind_q, kind_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] coeff_q, coeff_d;
  logic [1:0]        cidx_q, cidx_d;
  logic              dr_q, dr_d;
  logic              lc_q, lc_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;
  logic              proto_q, proto_d;
  logic              tmo_err_q, tmo_err_d;

  logic               w_pop;
  logic               w_push;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic [ENTRY_W-1:0] w_head;
  logic               w_proto_set;
  logic               w_tmo_set;

  // A full queue still accepts a word in the cycle the FSM pops one
  assign push_ready = (w_count != CNT_W'(DEPTH)) | w_pop;
  assign w_push     = push_valid & push_ready;
  assign busy       = (state_q != F_IDLE);

  feeder_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_reset (n_reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i ({push_kind, push_data}),
    .rdata_o (w_head),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  // Next-state, hold-register and registered-output logic for the handshake
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    kind_d      = kind_q;
    sample_d    = sample_q;
    coeff_d     = coeff_q;
    cidx_d      = cidx_q;
    done_d      = 1'b0;
    done_err_d  = 1'b0;
    w_pop       = 1'b0;
    w_proto_set = 1'b0;
    w_tmo_set   = 1'b0;

    case (state_q)
      F_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          kind_d = w_head[ENTRY_W-1];
          if (w_head[ENTRY_W-1] == KIND_COEFF) begin
            coeff_d = w_head[DATA_W-1:0];
            state_d = F_LC;
          end else begin
            sample_d = w_head[DATA_W-1:0];
            // A sample in the middle of a coefficient group is dropped
            if (cidx_q != 2'd0) begin
              w_proto_set = 1'b1;
            end else begin
              state_d = F_DR1;
            end
          end
        end
      end
      F_DR1: state_d = F_DR2;
      F_DR2: begin
        state_d = F_WRISE;
        tmo_d   = '0;
      end
      F_LC: begin
        state_d = F_WRISE;
        tmo_d   = '0;
      end
      F_WRISE: begin
        if (tmo_q == TMO_W'(TIMEOUT)) begin
          w_tmo_set = 1'b1;
          cidx_d    = 2'd0;
          state_d   = F_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (modwait) state_d = F_WFALL;
        end
      end
      F_WFALL: begin
        if (tmo_q == TMO_W'(TIMEOUT)) begin
          w_tmo_set = 1'b1;
          cidx_d    = 2'd0;
          state_d   = F_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (!modwait) begin
            state_d = F_IDLE;
            if (kind_q == KIND_SAMPLE) begin
              done_d     = 1'b1;
              done_err_d = err;
            end else begin
              cidx_d = cidx_q + 1'b1;
            end
          end
        end
      end
      default: state_d = F_IDLE;
    endcase

    // Strobes follow the strobe states by one register stage, so the
    // held word is settled a cycle before the strobe rises
    dr_d = (state_q == F_DR1) || (state_q == F_DR2);
    lc_d = (state_q == F_LC);

    // Set events take priority over a simultaneous clear
    proto_d   = w_proto_set | (proto_q   & ~clear_err);
    tmo_err_d = w_tmo_set   | (tmo_err_q & ~clear_err);
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= F_IDLE;
      tmo_q      <= '0;
      kind_q     <= KIND_SAMPLE;
      sample_q   <= '0;
      coeff_q    <= '0;
      cidx_q     <= 2'd0;
      dr_q       <= 1'b0;
      lc_q       <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      proto_q    <= 1'b0;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      kind_q     <= kind_d;
      sample_q   <= sample_d;
      coeff_q    <= coeff_d;
      cidx_q     <= cidx_d;
      dr_q       <= dr_d;
      lc_q       <= lc_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
      proto_q    <= proto_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign dr              = dr_q;
  assign lc              = lc_q;
  assign sample_data     = sample_q;
  assign fir_coefficient = coeff_q;
  assign done            = done_q;
  assign done_err        = done_err_q;
  assign coeff_idx       = cidx_q;
  assign proto_err       = proto_q;
  assign timeout_err     = tmo_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_feeder
// Description : Directed self-checking bench for fir_feeder with a simple
//               FIR controller model answering dr/lc with modwait/err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_feeder;

  logic        clk;
  logic        n_reset;
  logic        push_valid;
  logic        push_kind;
  logic [15:0] push_data;
  logic        push_ready;
  logic        clear_err;
  logic        modwait;
  logic        err;
  logic        dr;
  logic        lc;
  logic [15:0] sample_data;
  logic [15:0] fir_coefficient;
  logic        done;
  logic        done_err;
  logic [1:0]  coeff_idx;
  logic        busy;
  logic        proto_err;
  logic        timeout_err;

  int n_vec;
  int n_miss;

  // controller model controls
  logic mute;
  logic model_err;

  // monitor state
  int          lc_cnt;
  int          dr_cnt;
  int          done_cnt;
  logic        last_done_err;
  logic [15:0] coef_seen[$];
  int          idx_hist[$];
  logic [1:0]  prev_idx;

  fir_feeder #(
    .TIMEOUT (32),
    .DEPTH   (4)
  ) dut (
    .clk             (clk),
    .n_reset         (n_reset),
    .push_valid      (push_valid),
    .push_kind       (push_kind),
    .push_data       (push_data),
    .push_ready      (push_ready),
    .clear_err       (clear_err),
    .modwait         (modwait),
    .err             (err),
    .dr              (dr),
    .lc              (lc),
    .sample_data     (sample_data),
    .fir_coefficient (fir_coefficient),
    .done            (done),
    .done_err        (done_err),
    .coeff_idx       (coeff_idx),
    .busy            (busy),
    .proto_err       (proto_err),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic kind, input logic [15:0] data);
    @(negedge clk);
    push_valid = 1'b1;
    push_kind  = kind;
    push_data  = data;
    @(posedge clk);
    #1;
    push_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  // Monitor: sample DUT outputs on the falling edge
  always @(negedge clk) begin
    if (lc) begin
      lc_cnt++;
      coef_seen.push_back(fir_coefficient);
    end
    if (dr) dr_cnt++;
    if (done) begin
      done_cnt++;
      last_done_err = done_err;
    end
    if (coeff_idx != prev_idx) idx_hist.push_back(int'(coeff_idx));
    prev_idx = coeff_idx;
  end

  // Controller model: lc -> modwait for one cycle two cycles after lc rises;
  // dr -> modwait rises one cycle after dr falls, held three cycles, err
  // optionally raised as modwait drops
  initial begin
    modwait = 1'b0;
    err     = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!mute && lc) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        modwait = 1'b1;
        @(posedge clk); #1;
        modwait = 1'b0;
      end else if (!mute && dr) begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        modwait = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
        end
        modwait = 1'b0;
        err     = model_err;
        @(posedge clk); #1;
        err     = 1'b0;
      end
    end
  end

  initial begin
    int dr_before;
    int done_before;
    n_vec         = 0;
    n_miss        = 0;
    lc_cnt        = 0;
    dr_cnt        = 0;
    done_cnt      = 0;
    last_done_err = 1'b0;
    prev_idx      = 2'd0;
    mute          = 1'b0;
    model_err     = 1'b0;
    push_valid    = 1'b0;
    push_kind     = 1'b0;
    push_data     = 16'h0;
    clear_err     = 1'b0;
    n_reset       = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_eq("rst_strobes", {29'd0, dr, lc, done}, 32'd0);
    chk_eq("rst_flags", {28'd0, busy, proto_err, timeout_err, done_err}, 32'd0);
    chk_eq("rst_push_ready", {31'd0, push_ready}, 32'd1);
    chk_eq("rst_data", {sample_data, fir_coefficient}, 32'd0);
    chk_eq("rst_coeff_idx", {30'd0, coeff_idx}, 32'd0);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);

    // Four coefficients back-to-back
    idx_hist.delete();
    coef_seen.delete();
    for (int i = 1; i <= 4; i++) push_word(1'b1, 16'(i));
    repeat (60) @(negedge clk);
    chk_eq("coef_lc_count", lc_cnt, 32'd4);
    chk_eq("coef_seen_n", coef_seen.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < coef_seen.size()) chk_eq($sformatf("coef_val%0d", i), {16'd0, coef_seen[i]}, i + 1);
    end
    chk_eq("coef_idx_hist_n", idx_hist.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < idx_hist.size()) chk_eq($sformatf("coef_idx%0d", i), idx_hist[i], (i + 1) % 4);
    end
    chk_eq("coef_no_done", done_cnt, 32'd0);

    // Sample 0x1234: dr exactly 2 cycles from 2 edges after the push
    push_word(1'b0, 16'h1234);
    @(negedge clk); chk_eq("smp_dr_n0", {31'd0, dr}, 32'd0);
    @(negedge clk); chk_eq("smp_dr_n1", {31'd0, dr}, 32'd0);
    @(negedge clk); chk_eq("smp_dr_n2", {31'd0, dr}, 32'd1);
    chk_eq("smp_data_at_dr", {16'd0, sample_data}, 32'h1234);
    @(negedge clk); chk_eq("smp_dr_n3", {31'd0, dr}, 32'd1);
    @(negedge clk); chk_eq("smp_dr_n4", {31'd0, dr}, 32'd0);
    repeat (15) @(negedge clk);
    chk_eq("smp_done_cnt", done_cnt, 32'd1);
    chk_eq("smp_done_err", {31'd0, last_done_err}, 32'd0);
    chk_eq("smp_idle", {31'd0, busy}, 32'd0);

    // Sample with controller error, then a normal sample
    model_err = 1'b1;
    push_word(1'b0, 16'h00AA);
    repeat (20) @(negedge clk);
    chk_eq("err_done_cnt", done_cnt, 32'd2);
    chk_eq("err_done_err", {31'd0, last_done_err}, 32'd1);
    model_err = 1'b0;
    push_word(1'b0, 16'h0055);
    repeat (20) @(negedge clk);
    chk_eq("after_err_done_cnt", done_cnt, 32'd3);
    chk_eq("after_err_done_err", {31'd0, last_done_err}, 32'd0);
    chk_eq("after_err_data", {16'd0, sample_data}, 32'h0055);

    // Two coefficients then a sample: sample dropped, proto_err set
    dr_before = dr_cnt;
    push_word(1'b1, 16'h0010);
    push_word(1'b1, 16'h0020);
    push_word(1'b0, 16'h0099);
    repeat (40) @(negedge clk);
    chk_eq("proto_err_set", {31'd0, proto_err}, 32'd1);
    chk_eq("proto_no_dr", dr_cnt, dr_before);
    chk_eq("proto_coeff_idx", {30'd0, coeff_idx}, 32'd2);
    chk_eq("proto_coeff_val", {16'd0, fir_coefficient}, 32'h0020);
    chk_eq("proto_done_cnt", done_cnt, 32'd3);
    pulse_clear();
    @(negedge clk);
    chk_eq("proto_cleared", {31'd0, proto_err}, 32'd0);

    // Coefficient timeout from coeff_idx=2: idx forced back to 0
    mute = 1'b1;
    push_word(1'b1, 16'h0030);
    repeat (20) @(negedge clk);
    chk_eq("tmo_c_not_early", {30'd0, busy, timeout_err}, 32'd2);
    repeat (30) @(negedge clk);
    chk_eq("tmo_c_err", {31'd0, timeout_err}, 32'd1);
    chk_eq("tmo_c_idx", {30'd0, coeff_idx}, 32'd0);
    chk_eq("tmo_c_idle", {31'd0, busy}, 32'd0);
    pulse_clear();
    @(negedge clk);
    chk_eq("tmo_cleared", {31'd0, timeout_err}, 32'd0);

    // Sample timeout: dr sent, no modwait
    dr_before   = dr_cnt;
    done_before = done_cnt;
    push_word(1'b0, 16'h0777);
    repeat (20) @(negedge clk);
    chk_eq("tmo_s_not_early", {30'd0, busy, timeout_err}, 32'd2);
    repeat (30) @(negedge clk);
    chk_eq("tmo_s_err", {31'd0, timeout_err}, 32'd1);
    chk_eq("tmo_s_dr_cycles", dr_cnt - dr_before, 32'd2);
    chk_eq("tmo_s_no_done", done_cnt, done_before);
    chk_eq("tmo_s_idle_idx", {29'd0, busy, coeff_idx}, 32'd0);

    // Fill the queue while stalled, then reset mid-wait
    push_word(1'b0, 16'h0100);
    repeat (5) @(negedge clk);
    chk_eq("fill_stalled", {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk_eq($sformatf("fill_ready%0d", i), {31'd0, push_ready}, 32'd1);
      push_valid = 1'b1;
      push_kind  = 1'b0;
      push_data  = 16'(16'h0200 + i);
      @(posedge clk);
      #1;
      push_valid = 1'b0;
    end
    @(negedge clk);
    chk_eq("fill_full", {31'd0, push_ready}, 32'd0);
    push_word(1'b0, 16'h0205);
    @(negedge clk);
    chk_eq("fill_fifth_ignored", {31'd0, push_ready}, 32'd0);
    #2;
    n_reset = 1'b0;
    #1;
    chk_eq("mid_rst_strobes", {29'd0, dr, lc, done}, 32'd0);
    chk_eq("mid_rst_flags", {28'd0, busy, proto_err, timeout_err, done_err}, 32'd0);
    chk_eq("mid_rst_push_ready", {31'd0, push_ready}, 32'd1);
    chk_eq("mid_rst_data", {sample_data, fir_coefficient}, 32'd0);
    chk_eq("mid_rst_coeff_idx", {30'd0, coeff_idx}, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    mute    = 1'b0;
    dr_before = dr_cnt;
    repeat (30) @(negedge clk);
    chk_eq("post_rst_queue_empty", dr_cnt, dr_before);
    chk_eq("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
